// File: rtl/ptw_arbiter.sv
// Round-robin arbiter sharing one memory read port between I- and D-MMU page-table walkers; grant 1 cycle after req, rvalid 2 cycles after bus_ready.
// One read outstanding, reqs ignored until back in IDLE; PTW_ARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYCLES.
module ptw_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    input  logic        d_req,
    input  logic [63:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] rdata,
    output logic        err,
    output logic [63:0] bus_addr,
    output logic        bus_read,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ready
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner_d;
    logic        r_last_d;
    logic        r_i_gnt;
    logic        r_d_gnt;
    logic        r_i_rvalid;
    logic        r_d_rvalid;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] r_bus_addr;
    logic        r_bus_read;

    logic        w_grant;
    logic        w_sel_d;
    logic        w_done;
    logic        w_abort;
    logic        w_timeout_hit;

`ifdef PTW_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_grant) begin
            r_cnt <= '0;
        end else if (r_state == WAIT && !bus_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Counter holds k-1 at the k-th WAIT edge, so the abort lands on edge TIMEOUT_CYCLES.
    assign w_timeout_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel_d     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    // On a tie, whoever was not served last wins.
                    w_sel_d     = d_req && (!i_req || !r_last_d);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_timeout_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_d  <= 1'b0;
            r_last_d   <= 1'b0;
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_bus_addr <= '0;
            r_bus_read <= 1'b0;
        end else begin
            r_i_gnt    <= w_grant && !w_sel_d;
            r_d_gnt    <= w_grant && w_sel_d;
            r_i_rvalid <= (r_state == RESP) && !r_owner_d;
            r_d_rvalid <= (r_state == RESP) && r_owner_d;
            if (w_grant) begin
                r_owner_d  <= w_sel_d;
                r_last_d   <= w_sel_d;
                r_bus_addr <= w_sel_d ? d_addr : i_addr;
                r_bus_read <= 1'b1;
            end
            if (w_done) begin
                r_rdata    <= bus_rdata;
                r_err      <= 1'b0;
                r_bus_read <= 1'b0;
            end else if (w_abort) begin
                r_rdata    <= '0;
                r_err      <= 1'b1;
                r_bus_read <= 1'b0;
            end
        end
    end

    assign i_gnt    = r_i_gnt;
    assign d_gnt    = r_d_gnt;
    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign rdata    = r_rdata;
    assign err      = r_err;
    assign bus_addr = r_bus_addr;
    assign bus_read = r_bus_read;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: reset, single request, round-robin, stray bus_ready, mid-read reset, optional timeout.
module tb_ptw_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic        d_req;
    logic [63:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] bus_addr;
    logic        bus_read;
    logic [63:0] bus_rdata;
    logic        bus_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ptw_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .rdata     (rdata),
        .err       (err),
        .bus_addr  (bus_addr),
        .bus_read  (bus_read),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_addr    = '0;
        bus_rdata = '0;
        bus_ready = 1'b0;
        tick();
        tick();
        chk("rst_bus_read", bus_read, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_rdata",    rdata,    0);
        chk("rst_err",      err,      0);
        chk("rst_gnt",      {i_gnt, d_gnt}, 0);
        chk("rst_rvalid",   {i_rvalid, d_rvalid}, 0);
        rst = 1'b0;
        tick();
        chk("idle_no_req_read", bus_read, 0);

        // Single data-side request, bus answers three cycles after grant.
        d_req  = 1'b1;
        d_addr = 64'h8000_1008;
        tick();
        chk("t1_d_gnt",    d_gnt,    1);
        chk("t1_i_gnt",    i_gnt,    0);
        chk("t1_bus_read", bus_read, 1);
        chk("t1_bus_addr", bus_addr, 64'h8000_1008);
        d_req = 1'b0;
        tick();
        chk("t1_d_gnt_pulse", d_gnt,    0);
        chk("t1_read_held",   bus_read, 1);
        tick();
        bus_ready = 1'b1;
        bus_rdata = 64'h2000_04CF;
        tick();
        bus_ready = 1'b0;
        chk("t1_rvalid_not_yet", d_rvalid, 0);
        chk("t1_read_drop",      bus_read, 0);
        chk("t1_rdata",          rdata,    64'h2000_04CF);
        bus_rdata = 64'hDEAD_BEEF;
        tick();
        chk("t1_d_rvalid", d_rvalid, 1);
        chk("t1_i_rvalid", i_rvalid, 0);
        chk("t1_err",      err,      0);
        tick();
        chk("t1_rvalid_pulse", d_rvalid, 0);
        chk("t1_rdata_hold",   rdata,    64'h2000_04CF);

        // Both requesters held after a fresh reset: d, i, d, i.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 64'h0000_0000_1111_0000;
        d_addr = 64'h0000_0000_2222_0000;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            tick();
            chk($sformatf("rr%0d_d_gnt", k), d_gnt, exp_d);
            chk($sformatf("rr%0d_i_gnt", k), i_gnt, !exp_d);
            chk($sformatf("rr%0d_addr", k), bus_addr, exp_d ? d_addr : i_addr);
            tick();
            chk($sformatf("rr%0d_gnt_pulse", k), {i_gnt, d_gnt}, 0);
            bus_ready = 1'b1;
            bus_rdata = 64'h1000 + 64'(k);
            tick();
            bus_ready = 1'b0;
            tick();
            chk($sformatf("rr%0d_d_rvalid", k), d_rvalid, exp_d);
            chk($sformatf("rr%0d_i_rvalid", k), i_rvalid, !exp_d);
            chk($sformatf("rr%0d_rdata", k), rdata, 64'h1000 + 64'(k));
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // bus_ready outside WAIT must be ignored.
        bus_ready = 1'b1;
        bus_rdata = 64'h5555_5555;
        tick();
        tick();
        chk("t3_idle_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("t3_idle_rdata",  rdata, 64'h1003);
        bus_ready = 1'b0;
        i_req  = 1'b1;
        i_addr = 64'h0000_00AB_CDEF_0010;
        tick();
        chk("t3_i_gnt", i_gnt, 1);
        i_req  = 1'b0;
        i_addr = 64'h0;
        tick();
        tick();
        tick();
        chk("t3_addr_stable", bus_addr, 64'h0000_00AB_CDEF_0010);
        chk("t3_read_stable", bus_read, 1);
        chk("t3_no_rvalid",   {i_rvalid, d_rvalid}, 0);
        bus_ready = 1'b1;
        bus_rdata = 64'h0000_0000_0BAD_F00D;
        tick();
        bus_rdata = 64'h7777_7777;
        tick();
        chk("t3_i_rvalid", i_rvalid, 1);
        chk("t3_rdata",    rdata,    64'h0000_0000_0BAD_F00D);
        tick();
        bus_ready = 1'b0;
        chk("t3_stray_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("t3_stray_read",   bus_read, 0);
        chk("t3_stray_rdata",  rdata, 64'h0000_0000_0BAD_F00D);

        // Reset two cycles into WAIT abandons the read.
        d_req  = 1'b1;
        d_addr = 64'h0000_0000_3333_0008;
        tick();
        chk("t4_d_gnt", d_gnt, 1);
        d_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t4_async_read",  bus_read, 0);
        chk("t4_async_addr",  bus_addr, 0);
        chk("t4_async_rdata", rdata,    0);
        bus_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus_ready = 1'b0;
        tick();
        chk("t4_no_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("t4_idle_read", bus_read, 0);
        i_req  = 1'b1;
        i_addr = 64'h0000_0000_4444_0018;
        tick();
        chk("t4_i_gnt",  i_gnt,    1);
        chk("t4_addr",   bus_addr, 64'h0000_0000_4444_0018);
        i_req     = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = 64'h0000_0000_0000_4321;
        tick();
        bus_ready = 1'b0;
        tick();
        chk("t4_i_rvalid", i_rvalid, 1);
        chk("t4_rdata",    rdata,    64'h4321);
        tick();

`ifdef PTW_ARB_TIMEOUT_EN
        // Eight WAIT cycles with no bus_ready abort with err.
        d_req  = 1'b1;
        d_addr = 64'h0000_0000_5555_0000;
        tick();
        d_req = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        chk("to_still_waiting", bus_read, 1);
        tick();
        chk("to_read_drop", bus_read, 0);
        chk("to_err",       err,      1);
        chk("to_rdata",     rdata,    0);
        tick();
        chk("to_d_rvalid", d_rvalid, 1);
        tick();
        // bus_ready on the eighth cycle beats the timeout.
        i_req  = 1'b1;
        i_addr = 64'h0000_0000_6666_0000;
        tick();
        i_req = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        bus_ready = 1'b1;
        bus_rdata = 64'h0000_0000_0000_ABCD;
        tick();
        bus_ready = 1'b0;
        chk("tr_err",   err,   0);
        chk("tr_rdata", rdata, 64'hABCD);
        tick();
        chk("tr_i_rvalid", i_rvalid, 1);
        chk("tr_err_q",    err,      0);
`else
        // Without the timeout the read waits indefinitely.
        d_req  = 1'b1;
        d_addr = 64'h0000_0000_5555_0000;
        tick();
        d_req = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        chk("nt_still_waiting", bus_read, 1);
        chk("nt_no_rvalid",     d_rvalid, 0);
        chk("nt_err",           err,      0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
